// File: rtl/xcorr_pkg.sv
// Shared types and helpers for the xcorr FFT/IFFT framer.
package xcorr_pkg;

    localparam int XC_FFT_W = 16;

    typedef struct packed {
        logic signed [XC_FFT_W-1:0] q;
        logic signed [XC_FFT_W-1:0] i;
    } cplx_t;

    typedef enum logic [1:0] {IDLE, CFG, DATA} fsm_t;

    // Clamp a signed value to the range of a w-bit two's-complement number.
    function automatic int sat(input int x, input int w);
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/xcorr_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO is accepted
// only when a read happens in the same cycle.
module xcorr_sync_fifo #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [AW:0]   count_reg;
    logic          wr_ok;
    logic          rd_ok;

    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (wr_ok) wptr_reg <= wptr_reg + AW'(1);
            if (rd_ok) rptr_reg <= rptr_reg + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read combinationally so a freshly written word is visible next cycle.
    assign dout  = mem[rptr_reg];
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/xcorr_fft_framer.sv
// Front end / back end for the xcorr FFT core: buffers and frames input samples with
// a per-frame config word, and registers/saturates the core output.
module xcorr_fft_framer
    import xcorr_pkg::*;
#(
    parameter int DW        = 12,
    parameter int FFT_W     = 16,
    parameter int CFG_W     = 8,
    parameter int FIFO_AW   = 8,
    parameter int LOG2N_MIN = 3,
    parameter int LOG2N_MAX = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ival,
    input  logic [DW-1:0]      data_i,
    input  logic [DW-1:0]      data_q,
    input  logic [CFG_W-1:0]   conf,
    input  logic [3:0]         log2n,
    output logic [CFG_W-1:0]   cfg_tdata,
    output logic               cfg_tvalid,
    input  logic               cfg_tready,
    output logic [2*FFT_W-1:0] s_tdata,
    output logic               s_tvalid,
    input  logic               s_tready,
    output logic               s_tlast,
    input  logic [2*FFT_W-1:0] m_tdata,
    input  logic [7:0]         m_tuser,
    input  logic               m_tvalid,
    input  logic               m_tlast,
    output logic [DW-1:0]      odata_i,
    output logic [DW-1:0]      odata_q,
    output logic [7:0]         oexp,
    output logic               oval,
    output logic               oeop,
    output logic               ovf,
    output logic [15:0]        frame_cnt
);
    localparam int SW = 2 * FFT_W;
    localparam int CW = LOG2N_MAX;
    localparam logic [3:0]    N_MIN = 4'(LOG2N_MIN);
    localparam logic [3:0]    N_MAX = 4'(LOG2N_MAX);
    localparam logic [CW-1:0] ONES  = '1;

    fsm_t                 state_reg;
    logic [3:0]           n_lat_reg;
    logic [CW-1:0]        cnt_reg;
    logic [SW-1:0]        din;
    logic [SW-1:0]        head;
    logic                 full;
    logic                 empty;
    logic [FIFO_AW:0]     count;
    logic                 wr_ok;
    logic                 pop;
    logic                 more;
    logic [3:0]           n_sel;
    logic [CW-1:0]        last_idx;
    logic signed [FFT_W-1:0] m_i;
    logic signed [FFT_W-1:0] m_q;

    assign din = {FFT_W'($signed(data_q)), FFT_W'($signed(data_i))};

    xcorr_sync_fifo #(
        .DW (SW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (ival),
        .din   (din),
        .rd    (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign s_tvalid = (state_reg == DATA) && !empty;
    assign s_tdata  = s_tvalid ? head : '0;
    assign last_idx = ONES >> (N_MAX - n_lat_reg);
    assign s_tlast  = s_tvalid && (cnt_reg == last_idx);
    assign pop      = s_tvalid && s_tready;
    assign wr_ok    = ival && (!full || pop);
    // Data still queued after this cycle's pop, counting a sample arriving now.
    assign more     = (count > (FIFO_AW+1)'(1)) || wr_ok;
    assign n_sel    = (log2n < N_MIN) ? N_MIN : ((log2n > N_MAX) ? N_MAX : log2n);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cfg_tvalid <= 1'b0;
            cfg_tdata  <= '0;
            n_lat_reg  <= N_MIN;
            cnt_reg    <= '0;
            frame_cnt  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!empty || wr_ok) begin
                        state_reg  <= CFG;
                        cfg_tvalid <= 1'b1;
                        cfg_tdata  <= conf;
                        n_lat_reg  <= n_sel;
                    end
                end
                CFG: begin
                    if (cfg_tready) begin
                        state_reg  <= DATA;
                        cfg_tvalid <= 1'b0;
                    end
                end
                DATA: begin
                    if (pop) begin
                        if (cnt_reg == last_idx) begin
                            cnt_reg   <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                            if (more) begin
                                state_reg  <= CFG;
                                cfg_tvalid <= 1'b1;
                                cfg_tdata  <= conf;
                                n_lat_reg  <= n_sel;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    cfg_tvalid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ival && !wr_ok) begin
            ovf <= 1'b1;
        end
    end

    assign m_i = m_tdata[FFT_W-1:0];
    assign m_q = m_tdata[SW-1:FFT_W];

    // Output stage: data and exponent hold while no beat arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            odata_i <= '0;
            odata_q <= '0;
            oexp    <= '0;
            oval    <= 1'b0;
            oeop    <= 1'b0;
        end else begin
            oval <= m_tvalid;
            oeop <= m_tvalid && m_tlast;
            if (m_tvalid) begin
                odata_i <= DW'(sat(int'(m_i), DW));
                odata_q <= DW'(sat(int'(m_q), DW));
                oexp    <= m_tuser;
            end
        end
    end

endmodule

// File: tb/tb_xcorr_fft_framer.sv
// Self-checking bench for xcorr_fft_framer: randomized samples against a queue-based
// reference of beat order, frame lengths and config handshakes, plus output saturation.
module tb_xcorr_fft_framer;
    import xcorr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ival;
    logic [11:0] data_i, data_q;
    logic [7:0]  conf;
    logic [3:0]  log2n;
    logic        cfg_tready, s_tready;
    logic [31:0] m_tdata;
    logic [7:0]  m_tuser;
    logic        m_tvalid, m_tlast;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast;
    logic [11:0] odata_i, odata_q;
    logic [7:0]  oexp;
    logic        oval, oeop, ovf;
    logic [15:0] frame_cnt;

    logic        b_ival;
    logic [11:0] b_data_i, b_data_q;
    logic [7:0]  b_conf;
    logic [3:0]  b_log2n;
    logic        b_cfg_tready, b_s_tready;
    logic [31:0] b_m_tdata;
    logic [7:0]  b_m_tuser;
    logic        b_m_tvalid, b_m_tlast;
    logic [7:0]  b_cfg_tdata;
    logic        b_cfg_tvalid;
    logic [31:0] b_s_tdata;
    logic        b_s_tvalid, b_s_tlast;
    logic [11:0] b_odata_i, b_odata_q;
    logic [7:0]  b_oexp;
    logic        b_oval, b_oeop, b_ovf;
    logic [15:0] b_frame_cnt;

    always #5 clk = ~clk;

    xcorr_fft_framer dut (
        .clk(clk), .rst_n(rst_n), .ival(ival), .data_i(data_i), .data_q(data_q),
        .conf(conf), .log2n(log2n), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
        .cfg_tready(cfg_tready), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .s_tlast(s_tlast), .m_tdata(m_tdata), .m_tuser(m_tuser),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .odata_i(odata_i), .odata_q(odata_q),
        .oexp(oexp), .oval(oval), .oeop(oeop), .ovf(ovf), .frame_cnt(frame_cnt)
    );

    xcorr_fft_framer #(.FIFO_AW(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .ival(b_ival), .data_i(b_data_i), .data_q(b_data_q),
        .conf(b_conf), .log2n(b_log2n), .cfg_tdata(b_cfg_tdata), .cfg_tvalid(b_cfg_tvalid),
        .cfg_tready(b_cfg_tready), .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid),
        .s_tready(b_s_tready), .s_tlast(b_s_tlast), .m_tdata(b_m_tdata), .m_tuser(b_m_tuser),
        .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast), .odata_i(b_odata_i), .odata_q(b_odata_q),
        .oexp(b_oexp), .oval(b_oval), .oeop(b_oeop), .ovf(b_ovf), .frame_cnt(b_frame_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state: expected beats in order, and frame length bound to each cfg.
    logic [31:0] exp_q[$];
    int          len_q[$];
    logic [7:0]  exp_conf;
    int          cur_len = 0;
    int          beat_idx = 0;
    int          beats_total = 0;
    int          tlast_total = 0;
    int          cfg_total = 0;
    bit          cfg_pending = 1'b0;
    bit          stall_valid = 1'b0;
    logic [31:0] stall_data;
    bit          rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) s_tready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [15:0] sext(input logic [11:0] v);
        int x;
        x = int'(v);
        if (x >= 2048) x = x - 4096;
        return 16'(x);
    endfunction

    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            logic [11:0] di;
            logic [11:0] dq;
            cplx_t       c;
            di = 12'($urandom);
            dq = 12'($urandom);
            data_i = di;
            data_q = dq;
            ival   = 1'b1;
            c.i = sext(di);
            c.q = sext(dq);
            exp_q.push_back(c);
            step();
        end
        ival = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (beats_total < target && k < budget) begin
            step();
            k++;
        end
        check(tag, 64'(beats_total), 64'(target));
    endtask

    function automatic logic [11:0] ref_sat(input logic [15:0] raw);
        int v;
        v = int'(raw);
        if (v >= 32768) v = v - 65536;
        if (v > 2047) v = 2047;
        else if (v < -2048) v = -2048;
        return 12'(v);
    endfunction

    function automatic logic [15:0] rnd_lane();
        int v;
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        v = int'($urandom_range(0, 8191)) - 4096;
        return 16'(v);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] e;
            if (stall_valid) begin
                check("hold_valid", 64'(s_tvalid), 64'(1));
                check("hold_data", 64'(s_tdata), 64'(stall_data));
            end
            if (cfg_tvalid && cfg_tready) begin
                cfg_total++;
                check("cfg_data", 64'(cfg_tdata), 64'(exp_conf));
                check("cfg_expected", 64'(len_q.size() > 0), 64'(1));
                if (len_q.size() > 0) cur_len = len_q.pop_front();
                cfg_pending = 1'b1;
            end
            if (s_tvalid && s_tready) begin
                if (beat_idx == 0) begin
                    check("cfg_before_frame", 64'(cfg_pending), 64'(1));
                    cfg_pending = 1'b0;
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(s_tdata), 64'(e));
                end else begin
                    check("beat_unexpected", 64'(exp_q.size()), 64'(1));
                end
                check("beat_tlast", 64'(s_tlast), 64'(beat_idx == cur_len - 1));
                beats_total++;
                if (s_tlast) tlast_total++;
                if (beat_idx == cur_len - 1) beat_idx = 0;
                else beat_idx++;
            end
            stall_valid = s_tvalid && !s_tready;
            stall_data  = s_tdata;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bexp [8];
        logic [11:0] e_i, e_q;
        logic [7:0]  e_exp;
        logic        e_val, e_eop;
        int          nb, c0, t0, base;

        rst_n = 1'b0; ival = 1'b0; data_i = '0; data_q = '0; conf = '0; log2n = 4'd3;
        cfg_tready = 1'b1; s_tready = 1'b1;
        m_tdata = '0; m_tuser = '0; m_tvalid = 1'b0; m_tlast = 1'b0;
        b_ival = 1'b0; b_data_i = '0; b_data_q = '0; b_conf = '0; b_log2n = 4'd3;
        b_cfg_tready = 1'b1; b_s_tready = 1'b0;
        b_m_tdata = '0; b_m_tuser = '0; b_m_tvalid = 1'b0; b_m_tlast = 1'b0;
        exp_conf = '0;
        repeat (3) step();

        // Reset state
        check("rst_s_tvalid", 64'(s_tvalid), 64'(0));
        check("rst_s_tdata", 64'(s_tdata), 64'(0));
        check("rst_s_tlast", 64'(s_tlast), 64'(0));
        check("rst_cfg_tvalid", 64'(cfg_tvalid), 64'(0));
        check("rst_cfg_tdata", 64'(cfg_tdata), 64'(0));
        check("rst_oval", 64'(oval), 64'(0));
        check("rst_oeop", 64'(oeop), 64'(0));
        check("rst_odata", 64'({odata_q, odata_i, oexp}), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("rst_small_ovf", 64'(b_ovf), 64'(0));
        rst_n = 1'b1;
        step();

        // Test 1: log2n=3, 20 back-to-back samples, always ready
        conf = 8'hA5; exp_conf = 8'hA5; log2n = 4'd3;
        repeat (3) len_q.push_back(8);
        send(20);
        repeat (20) step();
        check("t1_beats", 64'(beats_total), 64'(20));
        check("t1_tlasts", 64'(tlast_total), 64'(2));
        check("t1_cfgs", 64'(cfg_total), 64'(3));
        check("t1_frame_cnt", 64'(frame_cnt), 64'(2));
        check("t1_waiting", 64'(s_tvalid), 64'(0));
        send(4);
        wait_beats(24, 50, "t1_tail_beats");
        repeat (3) step();
        check("t1_frame_cnt_end", 64'(frame_cnt), 64'(3));
        check("t1_tlasts_end", 64'(tlast_total), 64'(3));

        // Test 2: random s_tready, log2n=4, 64 samples
        conf = 8'h3C; exp_conf = 8'h3C; log2n = 4'd4;
        repeat (4) len_q.push_back(16);
        rand_rdy = 1'b1;
        send(64);
        wait_beats(88, 2000, "t2_beats");
        rand_rdy = 1'b0; s_tready = 1'b1;
        repeat (3) step();
        check("t2_tlasts", 64'(tlast_total), 64'(7));
        check("t2_frame_cnt", 64'(frame_cnt), 64'(7));
        check("t2_cfgs", 64'(cfg_total), 64'(7));
        check("t2_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t2_no_ovf", 64'(ovf), 64'(0));

        // Test 3: depth-8 instance, no readiness, 10 samples
        b_conf = 8'h11; b_log2n = 4'd3; b_s_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            b_data_i = 12'($urandom);
            b_data_q = 12'($urandom);
            if (k < 8) bexp[k] = {sext(b_data_q), sext(b_data_i)};
            b_ival = 1'b1;
            step();
            check($sformatf("t3_ovf_%0d", k), 64'(b_ovf), 64'(k >= 8));
        end
        b_ival = 1'b0;
        repeat (3) step();
        check("t3_ovf_sticky", 64'(b_ovf), 64'(1));
        b_s_tready = 1'b1;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b_s_tvalid && b_s_tready) begin
                if (nb < 8) begin
                    check($sformatf("t3_beat_%0d", nb), 64'(b_s_tdata), 64'(bexp[nb]));
                    check($sformatf("t3_tlast_%0d", nb), 64'(b_s_tlast), 64'(nb == 7));
                end
                nb++;
            end
        end
        step();
        check("t3_beats_out", 64'(nb), 64'(8));
        check("t3_frame_cnt", 64'(b_frame_cnt), 64'(1));
        check("t3_ovf_held", 64'(b_ovf), 64'(1));

        // Test 4: log2n 3->5 mid-frame, then clamping at both ends
        conf = 8'h5A; exp_conf = 8'h5A; log2n = 4'd3;
        len_q.push_back(8);
        len_q.push_back(32);
        send(3);
        log2n = 4'd5;
        send(37);
        wait_beats(128, 300, "t4_beats");
        repeat (3) step();
        check("t4_frame_cnt", 64'(frame_cnt), 64'(9));
        check("t4_tlasts", 64'(tlast_total), 64'(9));
        log2n = 4'd15;
        len_q.push_back(2048);
        send(2048);
        wait_beats(128 + 2048, 300, "t4_clamp_hi_beats");
        repeat (3) step();
        check("t4_clamp_hi_frame_cnt", 64'(frame_cnt), 64'(10));
        log2n = 4'd1;
        len_q.push_back(8);
        send(8);
        wait_beats(128 + 2048 + 8, 50, "t4_clamp_lo_beats");
        repeat (3) step();
        check("t4_clamp_lo_frame_cnt", 64'(frame_cnt), 64'(11));

        // Test 5: output register stage and saturation
        m_tdata = {16'h8000, 16'h7FF0}; m_tuser = 8'h12; m_tvalid = 1'b1; m_tlast = 1'b1;
        step();
        check("t5_sat_i", 64'(odata_i), 64'(12'h7FF));
        check("t5_sat_q", 64'(odata_q), 64'(12'h800));
        check("t5_eop", 64'(oeop), 64'(1));
        check("t5_val", 64'(oval), 64'(1));
        check("t5_exp", 64'(oexp), 64'(8'h12));
        m_tdata = {16'h0005, 16'h0005}; m_tlast = 1'b0; m_tuser = 8'h03;
        step();
        check("t5_small", 64'({odata_q, odata_i}), 64'({12'h005, 12'h005}));
        check("t5_no_eop", 64'(oeop), 64'(0));
        e_i = 12'h005; e_q = 12'h005; e_exp = 8'h03;
        for (int k = 0; k < 40; k++) begin
            m_tdata  = {rnd_lane(), rnd_lane()};
            m_tuser  = 8'($urandom);
            m_tvalid = 1'($urandom_range(0, 1));
            m_tlast  = 1'($urandom_range(0, 1));
            e_val = m_tvalid;
            e_eop = m_tvalid && m_tlast;
            if (m_tvalid) begin
                e_i   = ref_sat(m_tdata[15:0]);
                e_q   = ref_sat(m_tdata[31:16]);
                e_exp = m_tuser;
            end
            step();
            check($sformatf("t5_rand_%0d", k),
                  {31'd0, oval, oeop, odata_q, odata_i, oexp},
                  {31'd0, e_val, e_eop, e_q, e_i, e_exp});
        end
        m_tvalid = 1'b0; m_tlast = 1'b0;

        // Test 6: reset mid-frame after 3 of 8 beats
        conf = 8'h77; exp_conf = 8'h77; log2n = 4'd3;
        len_q.push_back(8);
        s_tready = 1'b0;
        send(8);
        repeat (2) step();
        base = beats_total;
        t0 = tlast_total;
        s_tready = 1'b1;
        wait_beats(base + 3, 20, "t6_three_beats");
        rst_n = 1'b0;
        exp_q.delete(); len_q.delete();
        beat_idx = 0; cfg_pending = 1'b0; stall_valid = 1'b0;
        step();
        check("t6_s_tvalid", 64'(s_tvalid), 64'(0));
        check("t6_s_tlast", 64'(s_tlast), 64'(0));
        check("t6_s_tdata", 64'(s_tdata), 64'(0));
        check("t6_cfg", 64'({cfg_tvalid, cfg_tdata}), 64'(0));
        check("t6_out", 64'({oval, oeop, odata_q, odata_i, oexp}), 64'(0));
        check("t6_frame_cnt", 64'(frame_cnt), 64'(0));
        check("t6_small_ovf", 64'(b_ovf), 64'(0));
        check("t6_no_tlast", 64'(tlast_total), 64'(t0));
        rst_n = 1'b1;
        step();
        c0 = cfg_total;
        base = beats_total;
        len_q.push_back(8);
        send(8);
        wait_beats(base + 8, 50, "t6_restart_beats");
        repeat (3) step();
        check("t6_restart_cfg", 64'(cfg_total), 64'(c0 + 1));
        check("t6_restart_frame_cnt", 64'(frame_cnt), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
